// File: rtl/lsu_uncache_handler_if.sv
// -----------------------------------------------------------------------------
// lsu_uncache_handler_if
//
// Bundles every handshake and bus signal of the uncached access engine:
//   wb_*  : write-buffer store request channel (request in, wb_ready out)
//   rb_*  : read-buffer load request channel and load data return channel
//   mem_* : uncached memory bus request channel and response channel
//
// Modports:
//   master : the handler's view. It masters the uncached memory bus and
//            serves the write/read buffers.
//   slave  : the surrounding environment (buffers + memory bus).
// -----------------------------------------------------------------------------
interface lsu_uncache_handler_if;

    // Write-buffer store request
    logic        wb_w;
    logic [31:0] wb_waddr;
    logic [1:0]  wb_size;
    logic [31:0] wb_data;
    logic        wb_ready;

    // Read-buffer load request and data return
    logic        rb_rvalid;
    logic [31:0] rb_raddr;
    logic [1:0]  rb_rsize;
    logic        rb_rready;
    logic        rb_uready;
    logic        rb_uvalid;
    logic [31:0] rb_udata;

    // Uncached memory bus
    logic        mem_uvalid;
    logic        mem_uwen;
    logic [31:0] mem_uaddr;
    logic [31:0] mem_udata;
    logic [3:0]  mem_ustrobe;
    logic        mem_mready;
    logic        mem_uready;
    logic        mem_mvalid;
    logic [31:0] mem_mdata;

    modport master (
        input  wb_w, wb_waddr, wb_size, wb_data,
        output wb_ready,
        input  rb_rvalid, rb_raddr, rb_rsize, rb_rready,
        output rb_uready, rb_uvalid, rb_udata,
        output mem_uvalid, mem_uwen, mem_uaddr, mem_udata, mem_ustrobe,
        input  mem_mready,
        output mem_uready,
        input  mem_mvalid, mem_mdata
    );

    modport slave (
        output wb_w, wb_waddr, wb_size, wb_data,
        input  wb_ready,
        output rb_rvalid, rb_raddr, rb_rsize, rb_rready,
        input  rb_uready, rb_uvalid, rb_udata,
        input  mem_uvalid, mem_uwen, mem_uaddr, mem_udata, mem_ustrobe,
        output mem_mready,
        input  mem_uready,
        output mem_mvalid, mem_mdata
    );

endinterface

// File: rtl/lsu_uncache_handler.sv
// -----------------------------------------------------------------------------
// lsu_uncache_handler
//
// Uncached access engine of the LSU. Accepts one uncached store (write buffer)
// or one uncached load (read buffer) at a time and issues a single 32-bit bus
// transaction with byte strobes. Load data is returned right-aligned and
// zero-extended. Stores win over loads so an older store reaches memory first.
//
// Ports:
//   clk         clock
//   resetn      synchronous active-low reset
//   bus         lsu_uncache_handler_if.master (wb_*, rb_*, mem_* channels)
//   uh_timeout  (only with UHANDLER_TIMEOUT_EN) one-cycle response timeout pulse
//
// Optional feature macro: UHANDLER_TIMEOUT_EN
//   Defined  : adds a response watchdog counter limited by TIMEOUT_CYCLES and
//              the uh_timeout output. A timed-out write returns to IDLE, a
//              timed-out read returns data 0.
//   Undefined: RESP waits indefinitely for the response.
// -----------------------------------------------------------------------------
module lsu_uncache_handler #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         resetn,
`ifdef UHANDLER_TIMEOUT_EN
    output logic                         uh_timeout,
`endif
    lsu_uncache_handler_if.master        bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_RET  = 2'd3;

    localparam logic [1:0] SZ_NIL  = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd3;

`ifdef UHANDLER_TIMEOUT_EN
    localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
`endif

    // Byte strobes for the addressed lanes; addr[0] is ignored for halves.
    function automatic logic [3:0] lane_strobe(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 4'b0001 << addr_lo;
            SZ_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate right-aligned store data across all lanes so the slave can
    // pick any lane purely from the strobes.
    function automatic logic [31:0] lane_replicate(input logic [1:0]  size,
                                                   input logic [31:0] data);
        case (size)
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            SZ_WORD: return data;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Pull the addressed bytes out of the full bus word, right-aligned and
    // zero-extended; sign extension belongs to the read buffer.
    function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                                 input logic [1:0]  addr_lo,
                                                 input logic [31:0] mdata);
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0:    return {24'h00_0000, mdata[7:0]};
                    2'd1:    return {24'h00_0000, mdata[15:8]};
                    2'd2:    return {24'h00_0000, mdata[23:16]};
                    2'd3:    return {24'h00_0000, mdata[31:24]};
                    default: return 32'h0000_0000;
                endcase
            end
            SZ_HALF: return {16'h0000, (addr_lo[1] ? mdata[31:16] : mdata[15:0])};
            SZ_WORD: return mdata;
            default: return 32'h0000_0000;
        endcase
    endfunction

    logic [1:0]  state_r,      state_s;
    logic [31:0] req_addr_r,   req_addr_s;
    logic [1:0]  req_size_r,   req_size_s;
    logic        req_wen_r,    req_wen_s;
    logic [31:0] req_data_r,   req_data_s;
    logic [3:0]  req_strobe_r, req_strobe_s;
    logic        mem_uvalid_r, mem_uvalid_s;
    logic        mem_uready_r, mem_uready_s;
    logic        rb_uvalid_r,  rb_uvalid_s;
    logic [31:0] rb_udata_r,   rb_udata_s;
    logic        wb_ready_s;
    logic        rb_uready_s;
`ifdef UHANDLER_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_s;
    logic             uh_timeout_r, uh_timeout_s;
`endif

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_s      = state_r;
        req_addr_s   = req_addr_r;
        req_size_s   = req_size_r;
        req_wen_s    = req_wen_r;
        req_data_s   = req_data_r;
        req_strobe_s = req_strobe_r;
        mem_uvalid_s = mem_uvalid_r;
        mem_uready_s = mem_uready_r;
        rb_uvalid_s  = rb_uvalid_r;
        rb_udata_s   = rb_udata_r;
        wb_ready_s   = 1'b0;
        rb_uready_s  = 1'b0;
`ifdef UHANDLER_TIMEOUT_EN
        tmo_cnt_s    = tmo_cnt_r;
        uh_timeout_s = 1'b0;
`endif

        case (state_r)
            ST_IDLE: begin
                wb_ready_s  = bus.wb_w;
                rb_uready_s = bus.rb_rvalid & ~bus.wb_w;
                if (bus.wb_w) begin
                    req_addr_s   = bus.wb_waddr;
                    req_size_s   = bus.wb_size;
                    req_wen_s    = 1'b1;
                    req_data_s   = lane_replicate(bus.wb_size, bus.wb_data);
                    req_strobe_s = lane_strobe(bus.wb_size, bus.wb_waddr[1:0]);
                    if (bus.wb_size != SZ_NIL) begin
                        state_s      = ST_REQ;
                        mem_uvalid_s = 1'b1;
                    end else begin
                        // Nil store: nothing to put on the bus.
                        state_s = ST_IDLE;
                    end
                end else if (bus.rb_rvalid) begin
                    req_addr_s   = bus.rb_raddr;
                    req_size_s   = bus.rb_rsize;
                    req_wen_s    = 1'b0;
                    req_data_s   = 32'h0000_0000;
                    req_strobe_s = lane_strobe(bus.rb_rsize, bus.rb_raddr[1:0]);
                    if (bus.rb_rsize != SZ_NIL) begin
                        state_s      = ST_REQ;
                        mem_uvalid_s = 1'b1;
                    end else begin
                        // Nil load: answer straight away with zero data.
                        state_s     = ST_RET;
                        rb_uvalid_s = 1'b1;
                        rb_udata_s  = 32'h0000_0000;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_REQ: begin
                if (bus.mem_mready) begin
                    state_s      = ST_RESP;
                    mem_uvalid_s = 1'b0;
                    mem_uready_s = 1'b1;
`ifdef UHANDLER_TIMEOUT_EN
                    tmo_cnt_s    = {TMO_W{1'b0}};
`endif
                end else begin
                    state_s = ST_REQ;
                end
            end

            ST_RESP: begin
                if (bus.mem_mvalid) begin
                    mem_uready_s = 1'b0;
                    if (req_wen_r) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s     = ST_RET;
                        rb_uvalid_s = 1'b1;
                        rb_udata_s  = load_extract(req_size_r, req_addr_r[1:0], bus.mem_mdata);
                    end
                end
`ifdef UHANDLER_TIMEOUT_EN
                else if (tmo_cnt_r == TMO_LAST) begin
                    // This silent cycle brings the count to TIMEOUT_CYCLES:
                    // give up on the response and leave RESP.
                    tmo_cnt_s    = tmo_cnt_r + TMO_ONE;
                    uh_timeout_s = 1'b1;
                    mem_uready_s = 1'b0;
                    if (req_wen_r) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s     = ST_RET;
                        rb_uvalid_s = 1'b1;
                        rb_udata_s  = 32'h0000_0000;
                    end
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMO_ONE;
                    state_s   = ST_RESP;
                end
`else
                else begin
                    state_s = ST_RESP;
                end
`endif
            end

            ST_RET: begin
                if (bus.rb_rready) begin
                    state_s     = ST_IDLE;
                    rb_uvalid_s = 1'b0;
                end else begin
                    state_s = ST_RET;
                end
            end

            default: begin
                state_s      = ST_IDLE;
                mem_uvalid_s = 1'b0;
                mem_uready_s = 1'b0;
                rb_uvalid_s  = 1'b0;
            end
        endcase
    end

    // State, request register and registered outputs; reset discards any
    // transaction in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            req_addr_r   <= 32'h0000_0000;
            req_size_r   <= 2'd0;
            req_wen_r    <= 1'b0;
            req_data_r   <= 32'h0000_0000;
            req_strobe_r <= 4'b0000;
            mem_uvalid_r <= 1'b0;
            mem_uready_r <= 1'b0;
            rb_uvalid_r  <= 1'b0;
            rb_udata_r   <= 32'h0000_0000;
`ifdef UHANDLER_TIMEOUT_EN
            tmo_cnt_r    <= {TMO_W{1'b0}};
            uh_timeout_r <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            req_addr_r   <= req_addr_s;
            req_size_r   <= req_size_s;
            req_wen_r    <= req_wen_s;
            req_data_r   <= req_data_s;
            req_strobe_r <= req_strobe_s;
            mem_uvalid_r <= mem_uvalid_s;
            mem_uready_r <= mem_uready_s;
            rb_uvalid_r  <= rb_uvalid_s;
            rb_udata_r   <= rb_udata_s;
`ifdef UHANDLER_TIMEOUT_EN
            tmo_cnt_r    <= tmo_cnt_s;
            uh_timeout_r <= uh_timeout_s;
`endif
        end
    end

    // Accept strobes are combinational on the request and forced low while
    // reset is asserted so every output reads 0 during reset.
    assign bus.wb_ready    = resetn & wb_ready_s;
    assign bus.rb_uready   = resetn & rb_uready_s;

    assign bus.mem_uvalid  = mem_uvalid_r;
    assign bus.mem_uwen    = req_wen_r;
    assign bus.mem_uaddr   = req_addr_r;
    assign bus.mem_udata   = req_data_r;
    assign bus.mem_ustrobe = req_strobe_r;
    assign bus.mem_uready  = mem_uready_r;
    assign bus.rb_uvalid   = rb_uvalid_r;
    assign bus.rb_udata    = rb_udata_r;
`ifdef UHANDLER_TIMEOUT_EN
    assign uh_timeout      = uh_timeout_r;
`endif

endmodule

// File: tb/tb_lsu_uncache_handler.sv
// -----------------------------------------------------------------------------
// tb_lsu_uncache_handler
//
// Directed bench for lsu_uncache_handler. Expected bus requests and expected
// load returns are queued when stimulus is driven; a negedge monitor pops and
// compares them whenever the handler completes a bus request or a data return.
// Cycle-level checks (latency, priority, stability, reset) are done inline.
// -----------------------------------------------------------------------------
module tb_lsu_uncache_handler;

    logic clk;
    logic resetn;
`ifdef UHANDLER_TIMEOUT_EN
    logic uh_timeout;
    int   tmo_pulses;
`endif

    lsu_uncache_handler_if bus();

    lsu_uncache_handler #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
`ifdef UHANDLER_TIMEOUT_EN
        .uh_timeout (uh_timeout),
`endif
        .bus        (bus)
    );

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
    } req_t;

    req_t        exp_req_q [$];
    logic [31:0] exp_rd_q  [$];
    req_t        mon_req;
    logic [31:0] mon_rd;
    logic [3:0]  byte_strb [4];
    logic [31:0] byte_exp  [4];

    int n_checks = 0;
    int n_fail   = 0;

    // Free-running clock, posedge at 5 + 10k.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic wen, input logic [31:0] addr,
                            input logic [3:0] strobe, input logic [31:0] data);
        req_t r;
        r.wen    = wen;
        r.addr   = addr;
        r.strobe = strobe;
        r.data   = data;
        exp_req_q.push_back(r);
    endtask

    // Scoreboard monitor: compares every bus request and every load return.
    always @(negedge clk) begin
        if (bus.mem_uvalid && bus.mem_mready) begin
            check_val("req_expected", 32'(exp_req_q.size() != 0), 32'd1);
            if (exp_req_q.size() != 0) begin
                mon_req = exp_req_q.pop_front();
                check_val("req_uwen",    32'(bus.mem_uwen),    32'(mon_req.wen));
                check_val("req_uaddr",   bus.mem_uaddr,        mon_req.addr);
                check_val("req_ustrobe", 32'(bus.mem_ustrobe), 32'(mon_req.strobe));
                check_val("req_udata",   bus.mem_udata,        mon_req.data);
            end
        end
        if (bus.rb_uvalid && bus.rb_rready) begin
            check_val("ret_expected", 32'(exp_rd_q.size() != 0), 32'd1);
            if (exp_rd_q.size() != 0) begin
                mon_rd = exp_rd_q.pop_front();
                check_val("ret_udata", bus.rb_udata, mon_rd);
            end
        end
    end

    // One complete transaction on a zero-wait bus, with latency checks.
    // exp_val is the lane data for a store or the returned data for a load.
    task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wdata, input logic [31:0] mdata,
                           input logic [3:0] exp_strobe, input logic [31:0] exp_val);
        if (wen) begin
            bus.wb_w = 1'b1; bus.wb_waddr = addr; bus.wb_size = size; bus.wb_data = wdata;
            push_req(1'b1, addr, exp_strobe, exp_val);
        end else begin
            bus.rb_rvalid = 1'b1; bus.rb_raddr = addr; bus.rb_rsize = size;
            push_req(1'b0, addr, exp_strobe, 32'h0);
            exp_rd_q.push_back(exp_val);
        end
        bus.mem_mready = 1'b1;
        @(negedge clk);
        check_val("txn_accept", 32'(wen ? bus.wb_ready : bus.rb_uready), 32'd1);
        cyc(); bus.wb_w = 1'b0; bus.rb_rvalid = 1'b0;
        @(negedge clk);
        check_val("txn_req_c1", 32'(bus.mem_uvalid), 32'd1);
        cyc(); bus.mem_mready = 1'b0; bus.mem_mvalid = 1'b1; bus.mem_mdata = mdata;
        @(negedge clk);
        check_val("txn_resp_c2", 32'(bus.mem_uready), 32'd1);
        cyc(); bus.mem_mvalid = 1'b0; bus.rb_rready = 1'b1;
        @(negedge clk);
        check_val("txn_ret_c3", 32'(bus.rb_uvalid), 32'(!wen));
        check_val("txn_c3_uready", 32'(bus.mem_uready), 32'd0);
        cyc(); bus.rb_rready = 1'b0;
    endtask

    initial begin
        byte_strb = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        byte_exp  = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044};

        resetn = 1'b0;
        bus.wb_w = 1'b1; bus.wb_waddr = 32'h1F00_0000; bus.wb_size = 2'd3; bus.wb_data = 32'h0;
        bus.rb_rvalid = 1'b0; bus.rb_raddr = 32'h0; bus.rb_rsize = 2'd0; bus.rb_rready = 1'b0;
        bus.mem_mready = 1'b0; bus.mem_mvalid = 1'b0; bus.mem_mdata = 32'h0;

        // Reset: outputs quiet even with a store request present.
        cyc(); cyc();
        @(negedge clk);
        check_val("rst_wb_ready",   32'(bus.wb_ready),   32'd0);
        check_val("rst_mem_uvalid", 32'(bus.mem_uvalid), 32'd0);
        check_val("rst_mem_uready", 32'(bus.mem_uready), 32'd0);
        check_val("rst_rb_uvalid",  32'(bus.rb_uvalid),  32'd0);
        check_val("rst_mem_uaddr",  bus.mem_uaddr,       32'd0);
`ifdef UHANDLER_TIMEOUT_EN
        check_val("rst_uh_timeout", 32'(uh_timeout), 32'd0);
`endif
        cyc(); resetn = 1'b1; bus.wb_w = 1'b0;
        cyc();

        // Store byte at lane 3, zero-wait bus.
        bus.wb_w = 1'b1; bus.wb_waddr = 32'h1F00_0003; bus.wb_size = 2'd1; bus.wb_data = 32'h0000_00AB;
        bus.mem_mready = 1'b1;
        push_req(1'b1, 32'h1F00_0003, 4'b1000, 32'hABAB_ABAB);
        @(negedge clk);
        check_val("st_wb_ready",  32'(bus.wb_ready),  32'd1);
        check_val("st_rb_uready", 32'(bus.rb_uready), 32'd0);
        cyc(); bus.wb_w = 1'b0;
        @(negedge clk);
        check_val("st_req_uvalid", 32'(bus.mem_uvalid), 32'd1);
        cyc(); bus.mem_mready = 1'b0; bus.mem_mvalid = 1'b1;
        @(negedge clk);
        check_val("st_resp_uready", 32'(bus.mem_uready), 32'd1);
        cyc(); bus.mem_mvalid = 1'b0;

        // Cycle 3 after the store accept: back in IDLE, a half load is taken.
        bus.rb_rvalid = 1'b1; bus.rb_raddr = 32'h1F00_0002; bus.rb_rsize = 2'd2; bus.mem_mready = 1'b1;
        push_req(1'b0, 32'h1F00_0002, 4'b1100, 32'h0);
        exp_rd_q.push_back(32'h0000_8765);
        @(negedge clk);
        check_val("st_idle_c3_uready", 32'(bus.mem_uready), 32'd0);
        check_val("ld_rb_uready",      32'(bus.rb_uready),  32'd1);
        cyc(); bus.rb_raddr = 32'h1F00_0001; bus.rb_rsize = 2'd1;
        @(negedge clk);
        check_val("ld_req_uvalid",   32'(bus.mem_uvalid), 32'd1);
        check_val("ld_busy_uready",  32'(bus.rb_uready),  32'd0);
        cyc(); bus.mem_mready = 1'b0; bus.mem_mvalid = 1'b1; bus.mem_mdata = 32'h8765_4321;
        cyc(); bus.mem_mvalid = 1'b0; bus.rb_rready = 1'b0;
        @(negedge clk);
        check_val("ld_uvalid_c3", 32'(bus.rb_uvalid), 32'd1);
        check_val("ld_udata_c3",  bus.rb_udata,       32'h0000_8765);
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge clk);
            check_val("ld_stall_uvalid",    32'(bus.rb_uvalid), 32'd1);
            check_val("ld_stall_udata",     bus.rb_udata,       32'h0000_8765);
            check_val("ld_stall_no_accept", 32'(bus.rb_uready), 32'd0);
        end
        cyc(); bus.rb_rready = 1'b1;
        cyc(); bus.rb_rready = 1'b0; bus.mem_mready = 1'b1;
        // Pending byte load at lane 1 is accepted now.
        push_req(1'b0, 32'h1F00_0001, 4'b0010, 32'h0);
        exp_rd_q.push_back(32'h0000_00BE);
        @(negedge clk);
        check_val("ld2_rb_uready", 32'(bus.rb_uready), 32'd1);
        cyc(); bus.rb_rvalid = 1'b0;
        cyc(); bus.mem_mready = 1'b0; bus.mem_mvalid = 1'b1; bus.mem_mdata = 32'h11CC_BE22;
        cyc(); bus.mem_mvalid = 1'b0; bus.rb_rready = 1'b1;
        @(negedge clk);
        check_val("ld2_uvalid", 32'(bus.rb_uvalid), 32'd1);
        cyc(); bus.rb_rready = 1'b0;

        // Store and load together: store wins; REQ stalls 5 cycles with a
        // stray mem_mvalid pulse that must be ignored.
        bus.wb_w = 1'b1; bus.wb_waddr = 32'h1F00_0010; bus.wb_size = 2'd3; bus.wb_data = 32'hDEAD_BEEF;
        bus.rb_rvalid = 1'b1; bus.rb_raddr = 32'h1F00_0020; bus.rb_rsize = 2'd3;
        push_req(1'b1, 32'h1F00_0010, 4'b1111, 32'hDEAD_BEEF);
        @(negedge clk);
        check_val("pri_wb_ready",  32'(bus.wb_ready),  32'd1);
        check_val("pri_rb_uready", 32'(bus.rb_uready), 32'd0);
        cyc(); bus.wb_w = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.mem_mvalid = (i == 2);
            @(negedge clk);
            check_val("stall_uvalid",  32'(bus.mem_uvalid),  32'd1);
            check_val("stall_uaddr",   bus.mem_uaddr,        32'h1F00_0010);
            check_val("stall_ustrobe", 32'(bus.mem_ustrobe), 32'hF);
            check_val("stall_udata",   bus.mem_udata,        32'hDEAD_BEEF);
            check_val("stall_uready",  32'(bus.mem_uready),  32'd0);
            check_val("stall_rb_uready", 32'(bus.rb_uready), 32'd0);
            cyc();
        end
        bus.mem_mvalid = 1'b0; bus.mem_mready = 1'b1;
        @(negedge clk);
        check_val("stall_release_uvalid", 32'(bus.mem_uvalid), 32'd1);
        cyc(); bus.mem_mready = 1'b0;
        @(negedge clk);
        check_val("pri_ld_wait_resp", 32'(bus.rb_uready), 32'd0);
        cyc();
        @(negedge clk);
        check_val("pri_resp_wait", 32'(bus.mem_uready), 32'd1);
        cyc(); bus.mem_mvalid = 1'b1;
        @(negedge clk);
        check_val("pri_ld_wait_ack", 32'(bus.rb_uready), 32'd0);
        cyc(); bus.mem_mvalid = 1'b0; bus.mem_mready = 1'b1;
        push_req(1'b0, 32'h1F00_0020, 4'b1111, 32'h0);
        exp_rd_q.push_back(32'hCAFE_F00D);
        @(negedge clk);
        check_val("pri_ld_accept", 32'(bus.rb_uready), 32'd1);
        cyc(); bus.rb_rvalid = 1'b0;
        cyc(); bus.mem_mready = 1'b0; bus.mem_mvalid = 1'b1; bus.mem_mdata = 32'hCAFE_F00D;
        cyc(); bus.mem_mvalid = 1'b0; bus.rb_rready = 1'b1;
        @(negedge clk);
        check_val("pri_ld_uvalid", 32'(bus.rb_uvalid), 32'd1);
        cyc(); bus.rb_rready = 1'b0;

        // Size/lane table.
        run_txn(1'b1, 32'h1F00_0006, 2'd2, 32'h0000_1234, 32'h0, 4'b1100, 32'h1234_1234);
        run_txn(1'b1, 32'h1F00_0000, 2'd2, 32'hFFFF_5678, 32'h0, 4'b0011, 32'h5678_5678);
        run_txn(1'b1, 32'h1F00_0008, 2'd3, 32'h0123_4567, 32'h0, 4'b1111, 32'h0123_4567);
        for (int i = 0; i < 4; i++)
            run_txn(1'b1, 32'h1F00_0100 + 32'(i), 2'd1, 32'h0000_005A, 32'h0, byte_strb[i], 32'h5A5A_5A5A);
        for (int i = 0; i < 4; i++)
            run_txn(1'b0, 32'h1F00_0200 + 32'(i), 2'd1, 32'h0, 32'h4433_2211, byte_strb[i], byte_exp[i]);
        run_txn(1'b0, 32'h1F00_0300, 2'd2, 32'h0, 32'h8765_4321, 4'b0011, 32'h0000_4321);
        run_txn(1'b0, 32'h1F00_0303, 2'd2, 32'h0, 32'h8765_4321, 4'b1100, 32'h0000_8765);
        run_txn(1'b0, 32'h1F00_0304, 2'd3, 32'h0, 32'h9ABC_DEF0, 4'b1111, 32'h9ABC_DEF0);

        // Nil store is a no-op; nil load returns 0 with no bus cycle.
        bus.wb_w = 1'b1; bus.wb_waddr = 32'h1F00_0050; bus.wb_size = 2'd0; bus.wb_data = 32'h1111_1111;
        @(negedge clk);
        check_val("nil_st_ready", 32'(bus.wb_ready), 32'd1);
        cyc(); bus.wb_w = 1'b0;
        bus.rb_rvalid = 1'b1; bus.rb_raddr = 32'h1F00_0054; bus.rb_rsize = 2'd0; bus.mem_mdata = 32'hFFFF_FFFF;
        exp_rd_q.push_back(32'h0);
        @(negedge clk);
        check_val("nil_st_no_bus",  32'(bus.mem_uvalid), 32'd0);
        check_val("nil_ld_accept",  32'(bus.rb_uready),  32'd1);
        cyc(); bus.rb_rvalid = 1'b0; bus.rb_rready = 1'b1;
        @(negedge clk);
        check_val("nil_ld_uvalid", 32'(bus.rb_uvalid),  32'd1);
        check_val("nil_ld_no_bus", 32'(bus.mem_uvalid), 32'd0);
        cyc(); bus.rb_rready = 1'b0;

        // Reset during RESP of a load discards it.
        bus.rb_rvalid = 1'b1; bus.rb_raddr = 32'h1F00_0030; bus.rb_rsize = 2'd3; bus.mem_mready = 1'b1;
        push_req(1'b0, 32'h1F00_0030, 4'b1111, 32'h0);
        @(negedge clk);
        check_val("rstm_accept", 32'(bus.rb_uready), 32'd1);
        cyc(); bus.rb_rvalid = 1'b0;
        cyc(); bus.mem_mready = 1'b0; resetn = 1'b0;
        @(negedge clk);
        check_val("rstm_in_resp", 32'(bus.mem_uready), 32'd1);
        cyc(); resetn = 1'b1;
        @(negedge clk);
        check_val("rstm_mem_uvalid",  32'(bus.mem_uvalid),  32'd0);
        check_val("rstm_mem_uready",  32'(bus.mem_uready),  32'd0);
        check_val("rstm_mem_uwen",    32'(bus.mem_uwen),    32'd0);
        check_val("rstm_mem_uaddr",   bus.mem_uaddr,        32'd0);
        check_val("rstm_mem_ustrobe", 32'(bus.mem_ustrobe), 32'd0);
        check_val("rstm_mem_udata",   bus.mem_udata,        32'd0);
        check_val("rstm_rb_uvalid",   32'(bus.rb_uvalid),   32'd0);
        check_val("rstm_rb_udata",    bus.rb_udata,         32'd0);
        check_val("rstm_wb_ready",    32'(bus.wb_ready),    32'd0);
        check_val("rstm_rb_uready",   32'(bus.rb_uready),   32'd0);
        cyc(); bus.mem_mvalid = 1'b1; bus.mem_mdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            cyc(); bus.mem_mvalid = 1'b0;
            @(negedge clk);
            check_val("rstm_late_no_ret", 32'(bus.rb_uvalid), 32'd0);
        end
        cyc();

`ifdef UHANDLER_TIMEOUT_EN
        // Response never arrives: one timeout pulse, zero data returned, a
        // late response is ignored.
        bus.rb_rvalid = 1'b1; bus.rb_raddr = 32'h1F00_0040; bus.rb_rsize = 2'd3; bus.mem_mready = 1'b1;
        push_req(1'b0, 32'h1F00_0040, 4'b1111, 32'h0);
        exp_rd_q.push_back(32'h0);
        @(negedge clk);
        check_val("tmo_accept", 32'(bus.rb_uready), 32'd1);
        cyc(); bus.rb_rvalid = 1'b0;
        cyc(); bus.mem_mready = 1'b0;
        tmo_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            bus.mem_mvalid = (i == 7);
            bus.mem_mdata  = 32'h7777_7777;
            @(negedge clk);
            if (uh_timeout) tmo_pulses++;
            cyc();
        end
        bus.mem_mvalid = 1'b0;
        check_val("tmo_pulses", 32'(tmo_pulses), 32'd1);
        bus.rb_rready = 1'b1;
        @(negedge clk);
        check_val("tmo_ret_uvalid", 32'(bus.rb_uvalid), 32'd1);
        cyc(); bus.rb_rready = 1'b0;
        cyc();
`endif

        check_val("req_q_drained", 32'(exp_req_q.size()), 32'd0);
        check_val("rd_q_drained",  32'(exp_rd_q.size()),  32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
